nibble_sort_ctrl: RTL and testbench

Sequential sorter that orders N 4-bit values using a single shared instance of the team's 4-bit magnitude comparator (`fourbit_comparator`, outputs g/l/e). The controller loads a packed vector and runs a fixed-schedule bubble sort, one compare-and-conditional-swap per clock. It returns the sorted vector with a one-cycle done pulse. It sits between a register-mapped load interface and downstream logic that needs ranked nibbles, such as priority selection or min/max extraction.

---
 rtl/nibble_sort_pkg.sv | 20 ++
 rtl/fourbit_comparator.sv | 15 +
 rtl/nibble_sort_ctrl.sv | 151 +++++++++++++++
 tb/tb_nibble_sort_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/nibble_sort_pkg.sv
// Shared types and constants for the nibble sorter: FSM states, element and
// counter widths, and the compare-count helper.
package nibble_sort_pkg;

   localparam int ELEM_W = 4;
   localparam int SWAP_W = 6;
   localparam int IDX_W  = 3;

   typedef enum logic [1:0] {
      IDLE,
      SORT,
      DONE
   } state_t;

   // Number of compare steps one full bubble-sort schedule takes for n elements.
   function automatic int N_CMP(input int n);
      return n * (n - 1) / 2;
   endfunction

endpackage

// File: rtl/fourbit_comparator.sv
// Shared 4-bit magnitude comparator: exactly one of g (x>y), l (x<y), e (x==y)
// is high for any pair of inputs.
module fourbit_comparator (
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic       g,
   output logic       l,
   output logic       e
);

   assign g = (x > y);
   assign l = (x < y);
   assign e = (x == y);

endmodule

// File: rtl/nibble_sort_ctrl.sv
// Sequential bubble sorter for N nibbles: one compare-and-conditional-swap per
// clock through a single shared comparator, fixed data-independent latency.
module nibble_sort_ctrl
   import nibble_sort_pkg::*;
#(
   parameter int N      = 4,
   parameter bit ASCEND = 1'b1
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ELEM_W*N-1:0]   din,
   output logic                  busy,
   output logic                  done,
   output logic [ELEM_W*N-1:0]   dout,
   output logic [SWAP_W-1:0]     swaps
);

   localparam logic [IDX_W-1:0] LAST_P = IDX_W'(N - 2);

   state_t              state;
   state_t              state_next;
   logic [ELEM_W-1:0]   work_buf    [N];
   logic [ELEM_W-1:0]   buf_swapped [N];
   logic [ELEM_W*N-1:0] buf_packed;
   logic [IDX_W-1:0]    p;
   logic [IDX_W-1:0]    j;
   logic [SWAP_W-1:0]   swap_cnt;
   logic [SWAP_W-1:0]   swap_cnt_next;
   logic [ELEM_W-1:0]   cmp_x;
   logic [ELEM_W-1:0]   cmp_y;
   logic                cmp_g;
   logic                cmp_l;
   logic                cmp_e;
   logic                accept;
   logic                do_swap;
   logic                last_j;
   logic                last_cmp;

   always_comb begin
      cmp_x = '0;
      cmp_y = '0;
      for (int i = 0; i < N - 1; i++) begin
         if (j == IDX_W'(i)) begin
            cmp_x = work_buf[i];
            cmp_y = work_buf[i + 1];
         end
      end
   end

   fourbit_comparator u_cmp (
      .x (cmp_x),
      .y (cmp_y),
      .g (cmp_g),
      .l (cmp_l),
      .e (cmp_e)
   );

   // Equal pairs never swap, which keeps the sort stable in either order.
   always_comb begin
      do_swap     = (state == SORT) && !cmp_e && (ASCEND ? cmp_g : cmp_l);
      buf_swapped = work_buf;
      for (int i = 0; i < N - 1; i++) begin
         if (do_swap && (j == IDX_W'(i))) begin
            buf_swapped[i]     = cmp_y;
            buf_swapped[i + 1] = cmp_x;
         end
      end
      swap_cnt_next = swap_cnt + SWAP_W'(do_swap);
      last_j        = (j == (LAST_P - p));
      last_cmp      = (p == LAST_P) && (j == '0);
   end

   always_comb begin
      buf_packed = '0;
      for (int i = 0; i < N; i++) begin
         buf_packed[ELEM_W*i +: ELEM_W] = buf_swapped[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = SORT;
            end else begin
               state_next = IDLE;
            end
         end
         SORT: begin
            if (last_cmp) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Results are captured from the post-swap view of the final compare so
   // they are valid in the same cycle done is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            work_buf[i] <= '0;
         end
         p        <= '0;
         j        <= '0;
         swap_cnt <= '0;
         dout     <= '0;
         swaps    <= '0;
      end else if (accept) begin
         for (int i = 0; i < N; i++) begin
            work_buf[i] <= din[ELEM_W*i +: ELEM_W];
         end
         p        <= '0;
         j        <= '0;
         swap_cnt <= '0;
      end else if (state == SORT) begin
         for (int i = 0; i < N; i++) begin
            work_buf[i] <= buf_swapped[i];
         end
         swap_cnt <= swap_cnt_next;
         if (last_j) begin
            j <= '0;
            p <= p + IDX_W'(1);
         end else begin
            j <= j + IDX_W'(1);
         end
         if (last_cmp) begin
            dout  <= buf_packed;
            swaps <= swap_cnt_next;
         end
      end
   end

   assign busy = (state == SORT);
   assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_sort_ctrl.sv
// Self-checking bench: an ascending and a descending sorter share stimulus and
// are compared against a counting-sort / inversion-count reference model.
module tb_nibble_sort_ctrl;

   localparam int N = 4;
   localparam int C = N * (N - 1) / 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [15:0]   din = '0;
   logic          busy_a, done_a, busy_d, done_d;
   logic [15:0]   dout_a, dout_d;
   logic [5:0]    swaps_a, swaps_d;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   nibble_sort_ctrl #(.N(N), .ASCEND(1'b1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .din   (din),
      .busy  (busy_a),
      .done  (done_a),
      .dout  (dout_a),
      .swaps (swaps_a)
   );

   nibble_sort_ctrl #(.N(N), .ASCEND(1'b0)) dut_d (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .din   (din),
      .busy  (busy_d),
      .done  (done_d),
      .dout  (dout_d),
      .swaps (swaps_d)
   );

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sorted result via value histogram; swap count of a stable bubble sort
   // equals the number of strictly out-of-order pairs.
   function automatic void model(input logic [15:0] v, input bit asc,
                                 output logic [15:0] sorted, output int inv);
      int cnt [16];
      int pos;
      logic [3:0] a [N];
      for (int k = 0; k < 16; k++) cnt[k] = 0;
      for (int i = 0; i < N; i++) begin
         a[i] = v[4*i +: 4];
         cnt[a[i]]++;
      end
      sorted = '0;
      pos = 0;
      for (int k = 0; k < 16; k++) begin
         int val;
         val = asc ? k : 15 - k;
         for (int r = 0; r < cnt[val]; r++) begin
            sorted[4*pos +: 4] = 4'(val);
            pos++;
         end
      end
      inv = 0;
      for (int i = 0; i < N; i++)
         for (int k = i + 1; k < N; k++)
            if (asc ? (a[i] > a[k]) : (a[i] < a[k])) inv++;
   endfunction

   // Called #1 after an edge with the DUT in IDLE or DONE. poke re-pulses
   // start and scrambles din mid-sort; hold leaves start high at the end.
   task automatic apply_stimulus(input logic [15:0] v, input bit poke, input bit hold);
      logic [15:0] exp_a, exp_d;
      int inv_a, inv_d, lat, busy_cnt;
      model(v, 1'b1, exp_a, inv_a);
      model(v, 1'b0, exp_d, inv_d);
      din   = v;
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      din = 16'($urandom);
      lat = 0;
      busy_cnt = 0;
      while (done_a !== 1'b1 && lat < 20) begin
         if (busy_a === 1'b1) busy_cnt++;
         @(posedge clk); #1;
         lat++;
         if (poke && lat == 2) begin
            start = 1'b1;
            din   = 16'($urandom);
         end else if (poke && lat == 3) begin
            start = 1'b0;
         end
      end
      check_output("latency", lat, C);
      check_output("busy_cycles", busy_cnt, C);
      check_output("done_d", done_d, 1'b1);
      check_output("busy_at_done", busy_a, 1'b0);
      check_output("dout_asc", dout_a, exp_a);
      check_output("swaps_asc", swaps_a, inv_a);
      check_output("dout_desc", dout_d, exp_d);
      check_output("swaps_desc", swaps_d, inv_d);
      if (!hold) begin
         @(posedge clk); #1;
         check_output("done_pulse_end", done_a, 1'b0);
         check_output("idle_busy", busy_a, 1'b0);
         check_output("dout_hold", dout_a, exp_a);
      end
   endtask

   initial begin
      $display("[TB] nibble_sort_ctrl bench start");
      #2;
      check_output("rst_busy", busy_a, 1'b0);
      check_output("rst_done", done_a, 1'b0);
      check_output("rst_dout", dout_a, 16'h0);
      check_output("rst_swaps", swaps_a, 6'd0);
      check_output("rst_dout_d", dout_d, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      apply_stimulus(16'h0213, 1'b0, 1'b0);
      check_output("t1_literal_dout", dout_a, 16'h3210);
      check_output("t1_literal_swaps", swaps_a, 6'd5);
      apply_stimulus(16'hF950, 1'b0, 1'b0);
      check_output("t2_literal_swaps", swaps_a, 6'd0);
      apply_stimulus(16'h05AF, 1'b0, 1'b0);
      check_output("t3_literal_dout", dout_a, 16'hFA50);
      check_output("t3_literal_swaps", swaps_a, 6'd6);
      apply_stimulus(16'h7777, 1'b0, 1'b0);
      apply_stimulus(16'h80F1, 1'b0, 1'b0);
      check_output("t4_literal_dout_d", dout_d, 16'h018F);

      apply_stimulus(16'h4C2A, 1'b1, 1'b0);

      apply_stimulus(16'h1B3E, 1'b0, 1'b1);
      apply_stimulus(16'hD065, 1'b0, 1'b0);

      // Abort a sort with an asynchronous reset between clock edges.
      din   = 16'h0213;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_output("busy_before_abort", busy_a, 1'b1);
      rst_n = 1'b0;
      #1;
      check_output("abort_dout", dout_a, 16'h0);
      check_output("abort_swaps", swaps_a, 6'd0);
      check_output("abort_busy", busy_a, 1'b0);
      check_output("abort_done", done_a, 1'b0);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         check_output("abort_no_done", done_a, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      apply_stimulus(16'h0213, 1'b0, 1'b0);

      for (int r = 0; r < 10; r++) begin
         apply_stimulus(16'($urandom), 1'b0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
